// File: rtl/alu_issue_scheduler_if.sv
// Bundle of the requester, ALU, flag-generator and response signals of alu_issue_scheduler.
// Optional macro ALU_SCHED_STICKY_OVF_EN adds sticky_clr/sticky_ovf.
`default_nettype none

interface alu_issue_scheduler_if #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
);
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic             req0_unit,  req1_unit;
  logic [OPW-1:0]   req0_op,    req1_op;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;

  logic             op_start;
  logic [OPW-1:0]   op_code;
  logic [WIDTH-1:0] op_a, op_b;
  logic             alu_select;
  logic [WIDTH-1:0] alu0_result, alu1_result;
  logic             zero_in, sign_in, carry_in, ovf_in;

  logic             res_valid, res_ready;
  logic [WIDTH-1:0] res_data;
  logic [3:0]       res_flags;
  logic             res_id;
`ifdef ALU_SCHED_STICKY_OVF_EN
  logic             sticky_clr, sticky_ovf;
`endif

  // master: the scheduler itself; slave: requesters, ALUs and response sink
  modport master (
    input  req0_valid, req1_valid, req0_unit, req1_unit, req0_op, req1_op,
    input  req0_a, req0_b, req1_a, req1_b,
    input  alu0_result, alu1_result, zero_in, sign_in, carry_in, ovf_in, res_ready,
`ifdef ALU_SCHED_STICKY_OVF_EN
    input  sticky_clr,
    output sticky_ovf,
`endif
    output req0_ready, req1_ready, op_start, op_code, op_a, op_b, alu_select,
    output res_valid, res_data, res_flags, res_id
  );

  modport slave (
    output req0_valid, req1_valid, req0_unit, req1_unit, req0_op, req1_op,
    output req0_a, req0_b, req1_a, req1_b,
    output alu0_result, alu1_result, zero_in, sign_in, carry_in, ovf_in, res_ready,
`ifdef ALU_SCHED_STICKY_OVF_EN
    output sticky_clr,
    input  sticky_ovf,
`endif
    input  req0_ready, req1_ready, op_start, op_code, op_a, op_b, alu_select,
    input  res_valid, res_data, res_flags, res_id
  );
endinterface

`default_nettype wire

// File: rtl/alu_issue_scheduler.sv
// Round-robin issue of one op at a time from two requesters to ALU0/ALU1, with flag capture.
// Optional macro ALU_SCHED_STICKY_OVF_EN adds a sticky overflow flag.
`default_nettype none

module alu_issue_scheduler #(
  parameter int WIDTH    = 32,
  parameter int OPW      = 4,
  parameter int ALU1_LAT = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_issue_scheduler_if.master bus
);
  typedef enum logic [1:0] {S_IDLE, S_EXEC0, S_EXEC1, S_RESP} state_t;

  localparam logic [3:0] CNT_LAST = 4'(ALU1_LAT - 1);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             last_grant_q, last_grant_d;
  logic             id_q, id_d;
  logic             sel_q, sel_d;
  logic [OPW-1:0]   code_q, code_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic [3:0]       rflags_q, rflags_d;
  logic             rid_q, rid_d;

  logic grant0, grant1, ready0, ready1, op_start, capture;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    sel_d        = sel_q;
    code_d       = code_q;
    a_d          = a_q;
    b_d          = b_q;
    rdata_d      = rdata_q;
    rflags_d     = rflags_q;
    rid_d        = rid_q;
    ready0       = 1'b0;
    ready1       = 1'b0;
    op_start     = 1'b0;
    capture      = 1'b0;

    // On a tie the requester that was not served last wins.
    grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant_q);
    grant0 = bus.req0_valid && !grant1;

    unique case (state_q)
      S_IDLE: begin
        if (grant0 || grant1) begin
          ready0  = grant0;
          ready1  = grant1;
          id_d    = grant1;
          sel_d   = grant1 ? bus.req1_unit : bus.req0_unit;
          code_d  = grant1 ? bus.req1_op   : bus.req0_op;
          a_d     = grant1 ? bus.req1_a    : bus.req0_a;
          b_d     = grant1 ? bus.req1_b    : bus.req0_b;
          cnt_d   = '0;
          state_d = sel_d ? S_EXEC1 : S_EXEC0;
        end
      end
      S_EXEC0: begin
        op_start = 1'b1;
        capture  = 1'b1;
        state_d  = S_RESP;
      end
      S_EXEC1: begin
        op_start = (cnt_q == 4'd0);
        if (cnt_q == CNT_LAST) begin
          capture = 1'b1;
          cnt_d   = '0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RESP: begin
        if (bus.res_ready) begin
          last_grant_d = rid_q;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (capture) begin
      rdata_d  = sel_q ? bus.alu1_result : bus.alu0_result;
      rflags_d = {bus.ovf_in, bus.carry_in, bus.sign_in, bus.zero_in};
      rid_d    = id_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      sel_q        <= 1'b0;
      code_q       <= '0;
      a_q          <= '0;
      b_q          <= '0;
      rdata_q      <= '0;
      rflags_q     <= '0;
      rid_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      sel_q        <= sel_d;
      code_q       <= code_d;
      a_q          <= a_d;
      b_q          <= b_d;
      rdata_q      <= rdata_d;
      rflags_q     <= rflags_d;
      rid_q        <= rid_d;
    end
  end

`ifdef ALU_SCHED_STICKY_OVF_EN
  logic sticky_q, sticky_d;

  // A coinciding clear loses to a new overflow capture.
  always_comb begin
    sticky_d = sticky_q;
    if (bus.sticky_clr)          sticky_d = 1'b0;
    if (capture && bus.ovf_in)   sticky_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_q <= 1'b0;
    else        sticky_q <= sticky_d;
  end

  assign bus.sticky_ovf = sticky_q;
`endif

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.op_start   = op_start;
  assign bus.op_code    = code_q;
  assign bus.op_a       = a_q;
  assign bus.op_b       = b_q;
  assign bus.alu_select = sel_q;
  assign bus.res_valid  = (state_q == S_RESP);
  assign bus.res_data   = rdata_q;
  assign bus.res_flags  = rflags_q;
  assign bus.res_id     = rid_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_scheduler.sv
// Directed self-checking bench for alu_issue_scheduler (ALU1_LAT=3); covers sticky overflow when
// ALU_SCHED_STICKY_OVF_EN is defined.
`default_nettype none

module tb_alu_issue_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   both_cnt = 0;

  alu_issue_scheduler_if #(.WIDTH(32), .OPW(4)) bus ();

  alu_issue_scheduler #(.WIDTH(32), .OPW(4), .ALU1_LAT(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.req0_ready && bus.req1_ready) both_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.req0_valid = 0; bus.req1_valid = 0; bus.req0_unit = 0; bus.req1_unit = 0;
    bus.req0_op = 0; bus.req1_op = 0; bus.req0_a = 0; bus.req0_b = 0; bus.req1_a = 0; bus.req1_b = 0;
    bus.alu0_result = 0; bus.alu1_result = 0;
    bus.zero_in = 0; bus.sign_in = 0; bus.carry_in = 0; bus.ovf_in = 0; bus.res_ready = 0;
`ifdef ALU_SCHED_STICKY_OVF_EN
    bus.sticky_clr = 0;
`endif

    // Reset state
    step(); step();
    check("rst_res_valid", 32'(bus.res_valid), 0);
    check("rst_op_start", 32'(bus.op_start), 0);
    check("rst_res_data", bus.res_data, 0);
    check("rst_alu_select", 32'(bus.alu_select), 0);
    rst_n = 1; step();

    // Single ALU0 overflow op from req0
    bus.req0_valid = 1; bus.req0_unit = 0; bus.req0_op = 4'h1;
    bus.req0_a = 32'h7FFF_FFFF; bus.req0_b = 32'h1; bus.alu0_result = 32'h8000_0000;
    bus.ovf_in = 1; bus.sign_in = 1; bus.carry_in = 0; bus.zero_in = 0;
    #1;
    check("t1_req0_ready_T", 32'(bus.req0_ready), 1);
    check("t1_req1_ready_T", 32'(bus.req1_ready), 0);
    step(); bus.req0_valid = 0;
    check("t1_op_start", 32'(bus.op_start), 1);
    check("t1_alu_select", 32'(bus.alu_select), 0);
    check("t1_op_a", bus.op_a, 32'h7FFF_FFFF);
    check("t1_op_code", 32'(bus.op_code), 1);
    check("t1_res_valid_T1", 32'(bus.res_valid), 0);
    step();
    check("t1_res_valid_T2", 32'(bus.res_valid), 1);
    check("t1_res_data", bus.res_data, 32'h8000_0000);
    check("t1_res_flags", 32'(bus.res_flags), 32'b1010);
    check("t1_res_id", 32'(bus.res_id), 0);
    bus.res_ready = 1; step(); bus.res_ready = 0;
    check("t1_res_valid_done", 32'(bus.res_valid), 0);

    // Both requesters valid from reset, round robin
    rst_n = 0; step(); rst_n = 1; step();
    bus.ovf_in = 0; bus.sign_in = 0;
    bus.req0_valid = 1; bus.req0_unit = 0; bus.req0_op = 4'h2; bus.req0_a = 32'h11;
    bus.req1_valid = 1; bus.req1_unit = 0; bus.req1_op = 4'h3; bus.req1_a = 32'h22;
    bus.alu0_result = 32'h55; bus.res_ready = 1;
    #1;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("rr%0d_req0_ready", i), 32'(bus.req0_ready), 32'(i % 2 == 0));
      check($sformatf("rr%0d_req1_ready", i), 32'(bus.req1_ready), 32'(i % 2 == 1));
      step();
      check($sformatf("rr%0d_op_a", i), bus.op_a, (i % 2 == 0) ? 32'h11 : 32'h22);
      step();
      check($sformatf("rr%0d_res_valid", i), 32'(bus.res_valid), 1);
      check($sformatf("rr%0d_res_id", i), 32'(bus.res_id), 32'(i % 2));
      step();
    end
    bus.req0_valid = 0; bus.req1_valid = 0; bus.res_ready = 0;
    check("rr_never_both_ready", 32'(both_cnt), 0);

    // req1 on ALU1, latency 3
    bus.req1_valid = 1; bus.req1_unit = 1; bus.req1_op = 4'h6; bus.req1_a = 32'h5;
    bus.alu1_result = 32'h0; bus.zero_in = 1; bus.carry_in = 1; bus.sign_in = 0; bus.ovf_in = 0;
    #1;
    check("t3_req1_ready_T", 32'(bus.req1_ready), 1);
    step(); bus.req1_valid = 0;
    check("t3_op_start_c0", 32'(bus.op_start), 1);
    check("t3_alu_select_c0", 32'(bus.alu_select), 1);
    step();
    check("t3_op_start_c1", 32'(bus.op_start), 0);
    check("t3_alu_select_c1", 32'(bus.alu_select), 1);
    check("t3_res_valid_c1", 32'(bus.res_valid), 0);
    step();
    check("t3_op_start_c2", 32'(bus.op_start), 0);
    check("t3_res_valid_c2", 32'(bus.res_valid), 0);
    step();
    check("t3_res_valid_T4", 32'(bus.res_valid), 1);
    check("t3_res_data", bus.res_data, 0);
    check("t3_res_flags", 32'(bus.res_flags), 32'b0101);
    check("t3_res_id", 32'(bus.res_id), 1);

    // Backpressure with req0 pending
    bus.req0_valid = 1; bus.req0_unit = 0; bus.req0_op = 4'h5; bus.req0_a = 32'h3; bus.req0_b = 32'h4;
    bus.alu0_result = 32'h7; bus.zero_in = 0; bus.carry_in = 0;
    #1;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("bp%0d_res_valid", i), 32'(bus.res_valid), 1);
      check($sformatf("bp%0d_res_data", i), bus.res_data, 0);
      check($sformatf("bp%0d_req0_ready", i), 32'(bus.req0_ready), 0);
      step();
    end
    bus.res_ready = 1; step(); bus.res_ready = 0;
    check("bp_req0_ready_after", 32'(bus.req0_ready), 1);
    check("bp_res_valid_after", 32'(bus.res_valid), 0);
    step(); bus.req0_valid = 0;
    check("bp_op_a", bus.op_a, 32'h3);
    step();
    check("bp_res_data", bus.res_data, 32'h7);
    check("bp_res_id", 32'(bus.res_id), 0);
    check("bp_res_flags", 32'(bus.res_flags), 0);
    bus.res_ready = 1; step(); bus.res_ready = 0;

    // Reset during EXEC1 count 1
    bus.req1_valid = 1; bus.req1_unit = 1; bus.req1_a = 32'h9; bus.alu1_result = 32'hAB;
    #1;
    check("t5_req1_ready", 32'(bus.req1_ready), 1);
    step(); bus.req1_valid = 0;
    check("t5_op_start_c0", 32'(bus.op_start), 1);
    step();
    check("t5_alu_select_c1", 32'(bus.alu_select), 1);
    rst_n = 0; #1;
    check("t5_rst_alu_select", 32'(bus.alu_select), 0);
    check("t5_rst_op_a", bus.op_a, 0);
    check("t5_rst_op_start", 32'(bus.op_start), 0);
    check("t5_rst_res_valid", 32'(bus.res_valid), 0);
    step(); step(); rst_n = 1;
    step(); step(); step(); step();
    check("t5_no_stale_res_valid", 32'(bus.res_valid), 0);
    check("t5_no_stale_op_start", 32'(bus.op_start), 0);
    bus.req0_valid = 1; bus.req0_unit = 0; bus.req0_a = 32'h44; bus.alu0_result = 32'h99;
    #1;
    check("t5_fresh_req0_ready", 32'(bus.req0_ready), 1);
    step(); bus.req0_valid = 0; step();
    check("t5_fresh_res_valid", 32'(bus.res_valid), 1);
    check("t5_fresh_res_data", bus.res_data, 32'h99);
    check("t5_fresh_res_id", 32'(bus.res_id), 0);
    bus.res_ready = 1; step(); bus.res_ready = 0;

`ifdef ALU_SCHED_STICKY_OVF_EN
    check("st_initial", 32'(bus.sticky_ovf), 0);
    bus.req0_valid = 1; bus.ovf_in = 1; bus.alu0_result = 32'h8000_0000;
    step(); bus.req0_valid = 0; step();
    check("st_set", 32'(bus.sticky_ovf), 1);
    bus.res_ready = 1; step(); bus.res_ready = 0;
    bus.req0_valid = 1; bus.ovf_in = 0; bus.alu0_result = 32'h1;
    step(); bus.req0_valid = 0; step();
    bus.res_ready = 1; step(); bus.res_ready = 0;
    check("st_persist", 32'(bus.sticky_ovf), 1);
    bus.sticky_clr = 1; step(); bus.sticky_clr = 0;
    check("st_cleared", 32'(bus.sticky_ovf), 0);
    bus.req0_valid = 1; bus.ovf_in = 1;
    step(); bus.req0_valid = 0; bus.sticky_clr = 1;
    step(); bus.sticky_clr = 0;
    check("st_set_wins", 32'(bus.sticky_ovf), 1);
    bus.res_ready = 1; step(); bus.res_ready = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "timeout");
  end
endmodule

`default_nettype wire
